// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus (CDB).
//
// Functional units raise writeback requests; one winner per cycle is granted
// combinationally and its pid/value are registered into a single broadcast
// stage that feeds the PRF, reservation stations and ROB.
//
// Ports:
//   clk        - clock; all state updates on posedge
//   rst        - asynchronous active-high reset
//   req_valid  - per-requester writeback request
//   req_pid    - per-requester destination physical register
//   req_value  - per-requester result data
//   req_ready  - per-requester grant (one-hot or zero)
//   flush      - pipeline flush; suppresses grants for the cycle
//   cdb_valid  - broadcast valid
//   cdb_pid    - broadcast destination physical register
//   cdb_value  - broadcast data
//   cdb_src    - index of the requester that produced the broadcast
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PID_W   = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][PID_W-1:0]       req_pid,
    input  logic [NUM_REQ-1:0][XLEN-1:0]        req_value,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                flush,
    output logic                                cdb_valid,
    output logic [PID_W-1:0]                    cdb_pid,
    output logic [XLEN-1:0]                     cdb_value,
    output logic [$clog2(NUM_REQ)-1:0]          cdb_src
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [PID_W-1:0] cdb_pid_q;
    logic [XLEN-1:0]  cdb_value_q;
    logic [SRC_W-1:0] cdb_src_q;

    logic             gnt_found;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W:0]   cand;
    logic             grant;
    logic [PID_W-1:0] gnt_pid;
    logic [XLEN-1:0]  gnt_value;

    // Rotating search starting at rr_ptr; the extra bit of cand lets the
    // index wrap correctly for non-power-of-two NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
            if (cand >= (SRC_W+1)'(NUM_REQ)) begin
                cand = cand - (SRC_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[SRC_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[SRC_W-1:0];
            end
        end
    end

    // Reset masks the grant so a result offered while rst is high is dropped.
    assign grant     = gnt_found && !flush && !rst;
    assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign gnt_pid   = req_pid[gnt_idx];
    assign gnt_value = req_value[gnt_idx];

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        if (grant) begin
            rr_ptr_d = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
            // Physical register 0 is hard-wired: accept the request but never broadcast it.
            cdb_valid_d = (gnt_pid != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_pid_q   <= '0;
            cdb_value_q <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            // Payload only moves on a real broadcast; otherwise it holds.
            if (cdb_valid_d) begin
                cdb_pid_q   <= gnt_pid;
                cdb_value_q <= gnt_value;
                cdb_src_q   <= gnt_idx;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_pid   = cdb_pid_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (NUM_REQ=4).
module tb_cdb_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned PID_W   = 6;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][PID_W-1:0] req_pid;
    logic [NUM_REQ-1:0][XLEN-1:0]  req_value;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          flush;
    logic                          cdb_valid;
    logic [PID_W-1:0]              cdb_pid;
    logic [XLEN-1:0]               cdb_value;
    logic [1:0]                    cdb_src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .XLEN    (XLEN),
        .PID_W   (PID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_pid   (req_pid),
        .req_value (req_value),
        .req_ready (req_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_pid   (cdb_pid),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cdb(input string tag, input logic v, input logic [PID_W-1:0] pid,
                             input logic [XLEN-1:0] val, input logic [1:0] src,
                             input logic [1:0] ptr);
        check_eq({tag, "_valid"}, 64'(cdb_valid), 64'(v));
        check_eq({tag, "_pid"},   64'(cdb_pid),   64'(pid));
        check_eq({tag, "_value"}, 64'(cdb_value), 64'(val));
        check_eq({tag, "_src"},   64'(cdb_src),   64'(src));
        check_eq({tag, "_ptr"},   64'(dut.rr_ptr_q), 64'(ptr));
    endtask

    // Called at a negedge: drive inputs, check the combinational grant, then
    // advance one full cycle so registered outputs are visible on return.
    task automatic cycle(input logic [3:0] v, input logic f, input logic [3:0] exp_ready,
                         input string tag);
        req_valid = v;
        flush     = f;
        #1;
        check_eq({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b1111;
        req_pid   = '0;
        req_value = '0;
        repeat (2) @(negedge clk);

        // Reset state; grants masked while rst is high.
        check_eq("rst_ready", 64'(req_ready), 64'h0);
        check_cdb("rst", 1'b0, 6'd0, 32'h0, 2'd0, 2'd0);

        // Single request on index 2.
        rst          = 1'b0;
        req_pid[2]   = 6'd5;
        req_value[2] = 32'hDEADBEEF;
        cycle(4'b0100, 1'b0, 4'b0100, "single");
        check_cdb("single", 1'b1, 6'd5, 32'hDEADBEEF, 2'd2, 2'd3);

        // pid 0 is accepted but dropped; payload holds previous broadcast.
        req_pid[0]   = 6'd0;
        req_value[0] = 32'h11111111;
        cycle(4'b0001, 1'b0, 4'b0001, "x0");
        check_cdb("x0", 1'b0, 6'd5, 32'hDEADBEEF, 2'd2, 2'd1);

        // Grant index 3 to bring the pointer back to 0.
        req_pid[3]   = 6'd7;
        req_value[3] = 32'h33333333;
        cycle(4'b1000, 1'b0, 4'b1000, "idx3");
        check_cdb("idx3", 1'b1, 6'd7, 32'h33333333, 2'd3, 2'd0);

        // Fairness: all valid, grants 0,1,2,3,0 back-to-back.
        for (int i = 0; i < NUM_REQ; i++) begin
            req_pid[i]   = PID_W'(i + 1);
            req_value[i] = 32'hA000_0000 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b0, 4'(1 << (k % 4)), "rr");
            check_cdb("rr", 1'b1, PID_W'(k % 4 + 1), 32'hA000_0000 + 32'(k % 4),
                      2'(k % 4), 2'((k + 1) % 4));
        end

        // Move pointer to 3, then wrap-around with 0b0011.
        cycle(4'b0100, 1'b0, 4'b0100, "pre_wrap");
        check_cdb("pre_wrap", 1'b1, 6'd3, 32'hA000_0002, 2'd2, 2'd3);
        cycle(4'b0011, 1'b0, 4'b0001, "wrap0");
        check_cdb("wrap0", 1'b1, 6'd1, 32'hA000_0000, 2'd0, 2'd1);
        cycle(4'b0011, 1'b0, 4'b0010, "wrap1");
        check_cdb("wrap1", 1'b1, 6'd2, 32'hA000_0001, 2'd1, 2'd2);

        // Flush: no grant, no broadcast, pointer held; then resume from 2.
        cycle(4'b1111, 1'b1, 4'b0000, "flush");
        check_cdb("flush", 1'b0, 6'd2, 32'hA000_0001, 2'd1, 2'd2);
        cycle(4'b1111, 1'b0, 4'b0100, "resume");
        check_cdb("resume", 1'b1, 6'd3, 32'hA000_0002, 2'd2, 2'd3);

        // Async reset mid-stream during back-to-back grants.
        cycle(4'b1111, 1'b0, 4'b1000, "pre_rst");
        check_cdb("pre_rst", 1'b1, 6'd4, 32'hA000_0003, 2'd3, 2'd0);
        req_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ready", 64'(req_ready), 64'h0);
        check_cdb("arst", 1'b0, 6'd0, 32'h0, 2'd0, 2'd0);
        @(negedge clk);
        check_cdb("arst_hold", 1'b0, 6'd0, 32'h0, 2'd0, 2'd0);
        rst = 1'b0;
        cycle(4'b0110, 1'b0, 4'b0010, "post_rst");
        check_cdb("post_rst", 1'b1, 6'd2, 32'hA000_0001, 2'd1, 2'd2);

        req_valid = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of functional-unit writeback requesters (2..8).
REQ-002 SHALL have parameter XLEN, default 32, result data width.
REQ-003 SHALL have parameter PID_W, default 6, physical register index width (PHYS_REG_IDX+1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester writeback request.
REQ-007 SHALL have port req_pid  input  NUM_REQ x PID_W  per-requester destination physical register.
REQ-008 SHALL have port req_value  input  NUM_REQ x XLEN  per-requester result.
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
REQ-010 SHALL have port flush  input  1  pipeline flush, e.g. branch mispredict.
REQ-011 SHALL have port cdb_valid  output  1  broadcast valid to PRF/RS/ROB.
REQ-012 SHALL have port cdb_pid  output  PID_W  broadcast destination.
REQ-013 SHALL have port cdb_value  output  XLEN  broadcast data.
REQ-014 SHALL have port cdb_src  output  clog2(NUM_REQ)  index of requester that won the broadcast.

Function
REQ-015 SHALL transfer a request on requester i in a cycle iff req_valid[i] and req_ready[i] are both high.
REQ-016 SHALL derive req_ready combinationally from req_valid, rr_ptr and flush; at most one bit high per cycle.
REQ-017 SHALL grant the first valid requester found by searching indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-018 SHALL keep all req_ready low when no req_valid is high or flush is high.
REQ-019 SHALL update rr_ptr to (g+1) mod NUM_REQ on the clock edge after a grant to index g; otherwise hold it.
REQ-020 SHALL register the granted pid/value/index into the output stage, giving cdb_valid exactly one cycle after the transfer, for one cycle.
REQ-021 SHALL hold cdb_valid high on consecutive cycles when grants occur back-to-back; throughput one result per cycle.
REQ-022 SHALL accept a granted request with pid 0, then discard it: cdb_valid stays 0, rr_ptr still advances. Physical register 0 is never written.
REQ-023 SHALL deassert cdb_valid in the cycle after flush is high, even if a grant occurred in the flush cycle's preceding edge window; flush does not modify rr_ptr.
REQ-024 SHALL hold cdb_pid, cdb_value and cdb_src at their last values when cdb_valid is 0.
REQ-025 SHALL not depend on req_pid/req_value of non-granted requesters; requesters hold valid/pid/value stable until accepted.
REQ-026 SHALL ignore X on req_pid/req_value when the matching req_valid is 0.
REQ-027 SHALL guarantee no requester waits more than NUM_REQ-1 grants while continuously valid and flush is low.

Reset
REQ-028 SHALL, on rst high, asynchronously clear rr_ptr to 0, cdb_valid to 0, cdb_pid to 0, cdb_value to 0 and cdb_src to 0.
REQ-029 SHALL drive all req_ready low while rst is high.
REQ-030 SHALL drop a result granted in the cycle rst asserts; no cdb_valid pulse follows reset release.
REQ-031 SHALL resume arbitration from index 0 on the first edge after rst deasserts.

Verification
REQ-032 Single request: reset; req_valid=0b0100, pid[2]=5, value[2]=0xDEADBEEF -> req_ready=0b0100 same cycle; next cycle cdb_valid=1, cdb_pid=5, cdb_value=0xDEADBEEF, cdb_src=2; rr_ptr=3.
REQ-033 Round-robin fairness: all four req_valid held high, ptr=0 -> grants 0,1,2,3,0 on successive cycles; cdb_valid high 5 consecutive cycles.
REQ-034 Wrap-around: ptr=3, req_valid=0b0011 -> grant 0, then grant 1 next cycle; cdb_src 0 then 1.
REQ-035 x0 drop: req_valid=0b0001, pid[0]=0 -> req_ready=0b0001; next cycle cdb_valid=0; rr_ptr=1.
REQ-036 Flush: req_valid=0b1111, flush=1 one cycle -> req_ready=0 that cycle; next cycle cdb_valid=0; rr_ptr unchanged; arbitration resumes the cycle after.
REQ-037 Async reset mid-stream: rst pulsed mid-cycle during back-to-back grants -> cdb_valid falls immediately without a clock edge; rr_ptr=0 after release; the first grant after release goes to the lowest valid index.
